// File: rtl/seg7_scan.sv
// seg7_scan: bus-programmable multiplexed 7-segment display driver.
// Registers hold hex digits, decimal points, blanking, raw segment patterns
// and a PWM brightness level. A free-running prescaler time-slices the
// digits. The top prescaler bits act as the PWM phase inside each slot.

// Active-low hex glyph decoder (seg[6:0] = g..a), lowercase b and d.
module seg7_hex_glyph (
    input  logic [3:0] nib,
    output logic [6:0] glyph
);
    // Pure lookup; a 0 bit lights the segment
    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end
endmodule

module seg7_scan #(
    parameter int NDIGITS  = 4,
    parameter int BASE     = 16,
    parameter int DIV_LOG2 = 10,
    parameter int PWM_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               rw,
    input  logic [31:0]        addr,
    inout  wire  [31:0]        data,
    output logic [7:0]         seg,
    output logic [NDIGITS-1:0] an
);
    localparam int NREGS = 4 + NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    // ---------------- bus decode ----------------
    logic [31:0] off;
    logic        in_win;
    logic        wr_en;
    logic        rd_en;

    assign off    = addr - 32'(BASE);
    assign in_win = (addr >= 32'(BASE)) && (off < 32'(NREGS));
    // Writes are dropped while reset is held so the reset values win
    assign wr_en  = enable && rw && in_win && !reset;
    assign rd_en  = enable && !rw && in_win;

    // ---------------- register file ----------------
    logic [4*NDIGITS-1:0] hex_r;
    logic [NDIGITS-1:0]   dp_r;
    logic [NDIGITS-1:0]   blank_r;
    logic                 raw_mode;
    logic [PWM_BITS:0]    bright;
    logic [7:0]           raw_seg [NDIGITS];

    // Shared registers at offsets 0..3; only implemented bits are stored
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_r    <= '0;
            dp_r     <= '0;
            blank_r  <= '0;
            raw_mode <= 1'b0;
            bright   <= (PWM_BITS+1)'(1) << PWM_BITS;
        end else if (wr_en) begin
            case (off)
                32'd0: hex_r   <= data[4*NDIGITS-1:0];
                32'd1: dp_r    <= data[NDIGITS-1:0];
                32'd2: blank_r <= data[NDIGITS-1:0];
                32'd3: begin
                    raw_mode <= data[0];
                    bright   <= data[8 +: PWM_BITS+1];
                end
                default: ;
            endcase
        end
    end

    // One raw-pattern register per digit, each with its own decode
    for (genvar g = 0; g < NDIGITS; g++) begin : g_raw
        // Raw segment pattern for digit g (1 = lit)
        always_ff @(posedge clk) begin
            if (reset)
                raw_seg[g] <= '0;
            else if (wr_en && off == 32'(4 + g))
                raw_seg[g] <= data[7:0];
        end
    end

    // Read mux; while reset is held the reset values are reported
    logic [31:0] rd_val;
    always_comb begin
        rd_val = '0;
        if (reset) begin
            if (off == 32'd3)
                rd_val[8 +: PWM_BITS+1] = (PWM_BITS+1)'(1) << PWM_BITS;
        end else begin
            case (off)
                32'd0: rd_val[4*NDIGITS-1:0] = hex_r;
                32'd1: rd_val[NDIGITS-1:0]   = dp_r;
                32'd2: rd_val[NDIGITS-1:0]   = blank_r;
                32'd3: begin
                    rd_val[0]               = raw_mode;
                    rd_val[8 +: PWM_BITS+1] = bright;
                end
                default: begin
                    for (int i = 0; i < NDIGITS; i++)
                        if (off == 32'(4 + i))
                            rd_val[7:0] = raw_seg[i];
                end
            endcase
        end
    end

    assign data = rd_en ? rd_val : 32'bz;

    // Upper data bits are legitimately ignored for most registers
    logic unused_data;
    assign unused_data = ^data;

    // ---------------- scan timing ----------------
    logic [DIV_LOG2-1:0] presc;
    logic [IDX_W-1:0]    idx;
    logic [PWM_BITS-1:0] phase;

    // Free prescaler; the digit index steps on the wrap clock
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + DIV_LOG2'(1);
            if (&presc)
                idx <= (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    assign phase = presc[DIV_LOG2-1 -: PWM_BITS];

    // Select the current digit's fields without out-of-range indexing
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_blank;
    logic [7:0] cur_raw;
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_raw   = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = hex_r[4*i +: 4];
                cur_dp    = dp_r[i];
                cur_blank = blank_r[i];
                cur_raw   = raw_seg[i];
            end
        end
    end

    logic [6:0] glyph;
    seg7_hex_glyph u_glyph (
        .nib   (cur_nib),
        .glyph (glyph)
    );

    logic active;
    assign active = !cur_blank && ({1'b0, phase} < bright);

    // Registered outputs; an is a single zero derived from idx, so it
    // can never select two digits at once
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= 8'hFF;
            an  <= '1;
        end else if (active) begin
            an  <= ~(NDIGITS'(1) << idx);
            seg <= raw_mode ? ~cur_raw : {~cur_dp, glyph};
        end else begin
            seg <= 8'hFF;
            an  <= '1;
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan: directed steps with a per-cycle scoreboard.
`timescale 1ns/1ps
module tb_seg7_scan;
    localparam int N = 4, BASE = 16, DL = 10, PB = 4;

    logic          clk = 1'b0;
    logic          reset, enable, rw, drv_en;
    logic [31:0]   addr, drv_val;
    wire  [31:0]   data;
    logic [7:0]    seg;
    logic [N-1:0]  an;

    assign data = drv_en ? drv_val : 32'bz;
    always #5 clk = ~clk;

    seg7_scan #(.NDIGITS(N), .BASE(BASE), .DIV_LOG2(DL), .PWM_BITS(PB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rw(rw),
        .addr(addr), .data(data), .seg(seg), .an(an)
    );

    typedef struct packed { logic [7:0] seg; logic [N-1:0] an; } out_t;
    out_t sb[$];
    int tests = 0, fails = 0, lit_cnt = 0;

    // Reference state of the display
    logic [15:0] m_hex;
    logic [3:0]  m_dp, m_blank;
    logic        m_raw;
    logic [4:0]  m_bright;
    logic [7:0]  m_rawv [N];
    int          m_presc, m_idx;
    logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hex = '0; m_dp = '0; m_blank = '0; m_raw = 1'b0; m_bright = 5'd16;
        for (int i = 0; i < N; i++) m_rawv[i] = '0;
        m_presc = 0; m_idx = 0;
    endtask

    function automatic out_t predict();
        out_t e;
        logic [N-1:0] one;
        int phase;
        one   = 1;
        phase = m_presc >> (DL - PB);
        e.seg = 8'hFF;
        e.an  = '1;
        if (!m_blank[m_idx] && phase < int'(m_bright)) begin
            e.an  = ~(one << m_idx);
            e.seg = m_raw ? ~m_rawv[m_idx] : {~m_dp[m_idx], glyph[m_hex[4*m_idx +: 4]]};
        end
        return e;
    endfunction

    // One clock: predict from the reference state seen by this edge, then compare
    task automatic tick();
        out_t e, o;
        int off;
        @(negedge clk);
        if (reset) begin
            e.seg = 8'hFF; e.an = '1;
            model_reset();
        end else begin
            e = predict();
            off = int'(addr) - BASE;
            if (enable && rw && addr >= BASE && off < 4 + N) begin
                case (off)
                    0: m_hex = drv_val[15:0];
                    1: m_dp = drv_val[3:0];
                    2: m_blank = drv_val[3:0];
                    3: begin m_raw = drv_val[0]; m_bright = drv_val[12:8]; end
                    default: m_rawv[off-4] = drv_val[7:0];
                endcase
            end
            m_presc++;
            if (m_presc == (1 << DL)) begin
                m_presc = 0;
                m_idx = (m_idx + 1) % N;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        if (an !== '1) lit_cnt++;
        check_eq("scan", {seg, an}, {o.seg, o.an});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        enable = 1'b1; rw = 1'b1; addr = a; drv_val = v; drv_en = 1'b1;
        tick();
        enable = 1'b0; drv_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        enable = 1'b1; rw = 1'b0; addr = a; drv_en = 1'b0;
        #1;
        check_eq(tag, data, exp);
        enable = 1'b0;
        tick();
    endtask

    // Run until the reference is about to show (digit d, prescaler p)
    task automatic wait_slot(input int d, input int p);
        int n = 0;
        while (!(m_idx == d && m_presc == p) && n < 20000) begin
            tick();
            n++;
        end
        check_eq("wait_bound", n < 20000, 1);
    endtask

    task automatic slot_chk(input string tag, input int d, input int p,
                            input logic [7:0] s, input logic [N-1:0] a);
        wait_slot(d, p);
        tick();
        check_eq({tag, "_seg"}, seg, s);
        check_eq({tag, "_an"}, an, a);
    endtask

    task automatic count_lit(input string tag, input int exp);
        lit_cnt = 0;
        repeat (4096) tick();
        check_eq(tag, lit_cnt, exp);
    endtask

    logic [7:0]   hx_seg [4] = '{8'hC0, 8'h80, 8'h88, 8'hF9};
    logic [N-1:0] hx_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        reset = 1'b1; enable = 1'b0; rw = 1'b0; addr = '0; drv_val = '0; drv_en = 1'b0;
        model_reset();
        // A write under reset must be ignored
        enable = 1'b1; rw = 1'b1; addr = BASE; drv_val = 32'hFFFF; drv_en = 1'b1;
        repeat (3) tick();
        enable = 1'b0; drv_en = 1'b0;
        reset = 1'b0;
        check_eq("rst_seg", seg, 8'hFF);
        check_eq("rst_an", an, 4'hF);
        rd_chk("rst_ctrl", BASE + 3, 32'h0000_1000);
        rd_chk("rst_hex", BASE, 32'h0);

        // Hex scan with default brightness
        wr(BASE, 32'h1A80);
        for (int d = 0; d < 4; d++) begin
            slot_chk("hex", d, 100, hx_seg[d], hx_an[d]);
            slot_chk("hex_end", d, 1023, hx_seg[d], hx_an[d]);
        end

        // Decimal point and blanking
        wr(BASE + 1, 32'h2);
        wr(BASE + 2, 32'h4);
        slot_chk("dp1", 1, 200, 8'h00, 4'hD);
        slot_chk("blank2", 2, 200, 8'hFF, 4'hF);
        wr(BASE + 1, 32'h0);
        wr(BASE + 2, 32'h0);

        // Brightness: PWM duty and its edges
        wr(BASE + 3, 32'h0400);
        tick();
        count_lit("lit_b4", 1024);
        slot_chk("b4_on", 0, 255, 8'hC0, 4'hE);
        slot_chk("b4_off", 0, 256, 8'hFF, 4'hF);
        wr(BASE + 3, 32'h0000);
        tick();
        count_lit("lit_b0", 0);
        wr(BASE + 3, 32'h1000);
        tick();
        count_lit("lit_b16", 4096);

        // Raw mode (brightness kept at full so the digit is visible)
        wr(BASE + 4, 32'h81);
        wr(BASE + 3, 32'h1001);
        slot_chk("raw0", 0, 100, 8'h7E, 4'hE);
        wr(BASE + 3, 32'h1000);
        check_eq("raw_hold", seg, 8'h7E);
        tick();
        check_eq("raw_exit", seg, 8'hC0);

        // Bus edges
        wr(BASE + 4 + N, 32'hFFFF_FFFF);
        wr(BASE - 1, 32'hFFFF_FFFF);
        rd_chk("oow_hex", BASE, 32'h1A80);
        rd_chk("oow_ctrl", BASE + 3, 32'h1000);
        rd_chk("oow_raw0", BASE + 4, 32'h81);
        rd_chk("oow_raw3", BASE + 3 + N, 32'h0);
        wr(BASE + 3, 32'hFFFF_FFFF);
        rd_chk("ctrl_bits", BASE + 3, 32'h1F01);
        wr(BASE + 3, 32'h1000);
        // With the DUT released, only the bench's pattern reaches the net
        drv_val = 32'hA5A5_5A5A; drv_en = 1'b1; enable = 1'b0; rw = 1'b0; addr = BASE + 3;
        #1;
        check_eq("hiz_en0", data, 32'hA5A5_5A5A);
        enable = 1'b1; addr = BASE + 4 + N;
        #1;
        check_eq("hiz_oow", data, 32'hA5A5_5A5A);
        enable = 1'b0; drv_en = 1'b0;
        tick();

        // Reset in the middle of digit 2
        slot_chk("pre_rst", 2, 300, 8'h88, 4'hB);
        reset = 1'b1;
        rd_chk("rst_rd_hex", BASE, 32'h0);
        check_eq("midrst_seg", seg, 8'hFF);
        check_eq("midrst_an", an, 4'hF);
        reset = 1'b0;
        tick();
        check_eq("post_rst_seg", seg, 8'hC0);
        check_eq("post_rst_an", an, 4'hE);
        rd_chk("post_rst_ctrl", BASE + 3, 32'h1000);
        repeat (50) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
